// File: rtl/kyber_op_sequencer.sv
// Phase/cooldown sequencer for the Kyber-512 core, with the encrypt message window.
// Define KYBER_SEQ_LOOPEND_EN to end phases on core_loop_end edges with a watchdog.
module kyber_op_sequencer #(
    parameter int unsigned START_CYC  = 5,
    parameter int unsigned PHASE_CYC  = 406,
    parameter int unsigned MSG_OFFSET = 320,
    parameter int unsigned MSG_LEN    = 256,
    parameter int unsigned MSG_TAIL   = 2,
    parameter int unsigned COOL_CYC   = 11,
    parameter int unsigned WD_CYC     = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [1:0]  op_sel,
    output logic [2:0]  core_control,
    output logic        core_start,
    input  logic        core_loop_end,
    input  logic        msg_in_valid,
    input  logic [15:0] msg_in_data,
    output logic        msg_in_ready,
    output logic [15:0] core_message,
    output logic        busy,
    output logic [2:0]  phase,
    output logic        done,
    output logic [1:0]  err,
    input  logic        err_clr
);

    typedef enum logic [1:0] {IDLE, RUN, COOL} state_t;

    localparam logic [10:0] START_LIM = 11'(START_CYC);
    localparam logic [10:0] PH_LAST   = 11'(PHASE_CYC - 1);
    localparam logic [10:0] ENC0_LAST = 11'(MSG_OFFSET + MSG_LEN + MSG_TAIL - 1);
    localparam logic [10:0] WIN_LO    = 11'(MSG_OFFSET);
    localparam logic [10:0] WIN_HI    = 11'(MSG_OFFSET + MSG_LEN);
    localparam logic [10:0] COOL_LAST = 11'(COOL_CYC - 1);

    state_t      state_q, state_d;
    logic [1:0]  op_sel_q, op_sel_d;
    logic [2:0]  phase_q, phase_d;
    logic [10:0] cyc_cnt_q, cyc_cnt_d;
    logic        done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic [15:0] msg_q, msg_d;

    logic        enc_ph0;
    logic        win;
    logic        last_phase;
    logic        phase_end;
    logic        wd_hit;
    logic [1:0]  err_set;

`ifdef KYBER_SEQ_LOOPEND_EN
    localparam logic [10:0] WD_LIM = 11'(WD_CYC);
    logic le_q, le_d;

    // Loop-end edges during the message window belong to the streaming, not a phase end.
    assign phase_end = core_loop_end & ~le_q & ~win;
    assign wd_hit    = (cyc_cnt_q >= WD_LIM);
    assign le_d      = core_loop_end;

    always_ff @(posedge clk) begin
        if (!reset) le_q <= 1'b0;
        else        le_q <= le_d;
    end
`else
    logic unused_loop_end;
    assign unused_loop_end = core_loop_end;
    assign phase_end = (cyc_cnt_q == (enc_ph0 ? ENC0_LAST : PH_LAST));
    assign wd_hit    = 1'b0;
`endif

    assign enc_ph0    = (op_sel_q == 2'b10) && (phase_q == 3'd0);
    assign win        = (state_q == RUN) && enc_ph0 && (cyc_cnt_q >= WIN_LO) && (cyc_cnt_q < WIN_HI);
    assign last_phase = (phase_q == (op_sel_q[1] ? 3'd1 : 3'd3));

    always_comb begin
        state_d   = state_q;
        op_sel_d  = op_sel_q;
        phase_d   = phase_q;
        cyc_cnt_d = cyc_cnt_q;
        done_d    = 1'b0;
        err_set   = 2'b00;
        msg_d     = 16'd0;

        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    op_sel_d  = op_sel;
                    state_d   = RUN;
                    phase_d   = 3'd0;
                    cyc_cnt_d = 11'd0;
                end
            end
            RUN: begin
                cyc_cnt_d = cyc_cnt_q + 11'd1;
                if (wd_hit) begin
                    err_set[1] = 1'b1;
                    state_d    = COOL;
                    cyc_cnt_d  = 11'd0;
                end else if (phase_end) begin
                    cyc_cnt_d = 11'd0;
                    if (last_phase) state_d = COOL;
                    else            phase_d = phase_q + 3'd1;
                end
            end
            COOL: begin
                cyc_cnt_d = cyc_cnt_q + 11'd1;
                if (cyc_cnt_q == COOL_LAST) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    phase_d   = 3'd0;
                    cyc_cnt_d = 11'd0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (win) begin
            if (msg_in_valid) msg_d = msg_in_data;
            else              err_set[0] = 1'b1;
        end

        // A new error in the same cycle as err_clr must survive the clear.
        err_d = (err_clr ? 2'b00 : err_q) | err_set;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            op_sel_q  <= 2'b00;
            phase_q   <= 3'd0;
            cyc_cnt_q <= 11'd0;
            done_q    <= 1'b0;
            err_q     <= 2'b00;
            msg_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            op_sel_q  <= op_sel_d;
            phase_q   <= phase_d;
            cyc_cnt_q <= cyc_cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            msg_q     <= msg_d;
        end
    end

    assign op_ready     = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign core_control = (state_q == RUN) ? {1'b1, op_sel_q} : 3'b000;
    assign core_start   = (state_q == RUN) && (phase_q == 3'd0) && (cyc_cnt_q < START_LIM);
    assign msg_in_ready = win;
    assign core_message = msg_q;
    assign phase        = phase_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: doc/kyber_op_sequencer.md
Name: kyber_op_sequencer

Overview:
- Sequences the Kyber-512 core through one complete operation: keygen-A, keygen-B, encrypt or decrypt.
- Drives the core's `control` and `start` inputs phase by phase and inserts the mandatory cooldown.
- During encryption, streams 256 message coefficients into the core inside a fixed cycle window.
- Sits between the host/command logic and the Kyber_512 core, and replaces the hand-timed stimulus used today.

Parameters:
- START_CYC, 5: cycles `core_start` is held high at the beginning of phase 0.
- PHASE_CYC, 406: length of a standard phase in cycles.
- MSG_OFFSET, 320: cycle within encrypt phase 0 at which the message window opens.
- MSG_LEN, 256: number of message coefficients streamed.
- MSG_TAIL, 2: cycles after the window closes before encrypt phase 0 ends (encrypt phase 0 length = 320 + 256 + 2 = 578).
- COOL_CYC, 11: cooldown cycles with `core_control` = 3'b000.
- WD_CYC, 1024: per-phase watchdog limit (used only with the macro).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- op_valid  in  1  operation request.
- op_ready  out  1  sequencer idle; a request is accepted when op_valid & op_ready.
- op_sel  in  2  00 keygen-A, 01 keygen-B, 10 encrypt, 11 decrypt.
- core_control  out  3  control code to the core.
- core_start  out  1  start pulse to the core.
- core_loop_end  in  1  core loop_end (ignored unless macro is defined).
- msg_in_valid  in  1  upstream message coefficient valid.
- msg_in_data  in  16  upstream message coefficient.
- msg_in_ready  out  1  message window open.
- core_message  out  16  message coefficient to the core.
- busy  out  1  operation in progress (including cooldown).
- phase  out  3  current phase index.
- done  out  1  one-cycle completion pulse.
- err  out  2  sticky error flags: [0] message underrun, [1] watchdog timeout.
- err_clr  in  1  clears err.

Behaviour:
- Reset (reset = 0 at a clk edge): state IDLE; op_ready = 1; all other outputs = 0. Reset applies mid-operation as well, aborting any transfer.
- States and transitions: IDLE -> RUN -> COOL -> IDLE.
- IDLE:
  - op_ready = 1.
  - On accept at cycle 0, op_sel is latched. From cycle 1: core_control = {1'b1, op_sel}, busy = 1, op_ready = 0, phase = 0, cyc_cnt = 0.
  - op_valid while busy is ignored.
- RUN:
  - core_start = 1 while phase = 0 and cyc_cnt < START_CYC; otherwise 0.
  - Phase counts: ops 00 and 01 run 4 phases; ops 10 and 11 run 2 phases.
  - Phase length is PHASE_CYC, except encrypt phase 0, which is MSG_OFFSET + MSG_LEN + MSG_TAIL.
  - At the last cycle of a phase: cyc_cnt returns to 0 and phase increments. After the final phase the state moves to COOL.
  - core_control is held constant across phases.
- Message window (op 10, phase 0, MSG_OFFSET <= cyc_cnt < MSG_OFFSET + MSG_LEN):
  - msg_in_ready = 1 during the window; 0 at all other times.
  - core_message is registered: it equals msg_in_data one cycle after a beat with msg_in_valid & msg_in_ready; otherwise it is 0.
  - msg_in_ready & !msg_in_valid sets err[0] and that beat's core_message = 0. The window is not extended and the operation continues.
- COOL:
  - core_control = 0, core_start = 0 for COOL_CYC cycles.
  - Then done = 1 for one cycle, with busy = 0, phase = 0 and op_ready = 1 in that same cycle.
- err:
  - err_clr clears both bits.
  - If a set event and err_clr occur in the same cycle, the set wins.
  - err persists across operations until cleared or reset.
- Arithmetic: cyc_cnt is 11 bits, wide enough for WD_CYC; no wrap-around can occur.

Optional Feature:
- Macro: KYBER_SEQ_LOOPEND_EN.
- Defined:
  - A phase ends on the cycle after a rising edge of core_loop_end (edge detected against its registered previous value), instead of at a fixed count.
  - Edges that fall inside an encrypt message window are ignored.
  - If cyc_cnt reaches WD_CYC without an edge: err[1] is set and the state goes directly to COOL, with done still pulsed.
- Undefined: core_loop_end is unused, phases are purely count-based, and err[1] is tied to 0.

Test Plan:
- Keygen-A: op_sel = 00 accepted at cycle 0 -> core_control = 100 over cycles 1..1624; core_start high cycles 1..5 only; phase steps 0, 1, 2, 3 at cycles 1, 407, 813, 1219; core_control = 000 over cycles 1625..1635; done at cycle 1636; err = 00.
- Encrypt: op_sel = 10, upstream supplies 256 valid coefficients (3840, 3839, 3840, 1, ...) -> msg_in_ready high cycles 321..576; core_message = 3840 at cycle 322, 3839 at 323, ...; phase 1 starts at cycle 579; done at cycle 1 + 578 + 406 + 11 = 996.
- Underrun: same as the encrypt case, but msg_in_valid is dropped for one beat at cycle 331 -> err = 01 from cycle 332 and core_message = 0 at cycle 332; done still at 996; err_clr then returns err to 00.
- Reset mid-op: decrypt (op_sel = 11) in progress, reset = 0 at cycle 500 -> next edge: core_control = 000, busy = 0, op_ready = 1; no done pulse; a new op is accepted normally afterwards.
- Busy rejection: op_valid held high during an operation -> no second accept until the cycle done is asserted; the second op starts the following cycle.
- Macro build: core_loop_end pulses at cycle 200 of each phase -> each phase is 201 cycles long; with core_loop_end held at 0 -> err = 10 at cyc_cnt = 1024, then cooldown and done.
